// File: rtl/mdu_seq.sv
// Multiply/divide sequencer for the EX stage: multi-cycle multiply, 32-step
// restoring divide, owns HI/LO and stalls the pipeline until the op retires.
module mdu_seq #(
  parameter int MUL_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mdu_op_i,
  input  logic        op_valid_i,
  input  logic        flush_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        stall_o,
  output logic [31:0] result_o,
  output logic        result_valid_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        busy_o
);

  localparam logic [3:0] OP_DIV   = 4'd1;
  localparam logic [3:0] OP_DIVU  = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_MULT  = 4'd4;
  localparam logic [3:0] OP_MULTU = 4'd5;
  localparam logic [3:0] OP_MFHI  = 4'd6;
  localparam logic [3:0] OP_MFLO  = 4'd7;
  localparam logic [3:0] OP_MTHI  = 4'd8;
  localparam logic [3:0] OP_MTLO  = 4'd9;

  localparam logic [4:0] MUL_LAST = 5'(MUL_LATENCY - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, quo_q;
  logic [32:0] rem_q;
  logic        qsign_q, rsign_q, dz_q;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic        is_div_op, is_mul_op, rs_neg, rt_neg, take;
  logic [33:0] rem_shift, diff;
  logic [31:0] quo_fix, rem_fix;
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;

  assign is_div_op = (mdu_op_i == OP_DIV) || (mdu_op_i == OP_DIVU);
  assign is_mul_op = (mdu_op_i == OP_MUL) || (mdu_op_i == OP_MULT) || (mdu_op_i == OP_MULTU);
  assign rs_neg    = rs_data_i[31] && (mdu_op_i == OP_DIV);
  assign rt_neg    = rt_data_i[31] && (mdu_op_i == OP_DIV);

  // Restoring step: shift in the next dividend bit, keep the difference if it did not borrow
  assign rem_shift = {rem_q, quo_q[31]};
  assign diff      = rem_shift - {2'b00, b_q};
  assign take      = ~diff[33];

  // A zero divisor leaves |A| in the remainder; only the quotient needs forcing
  assign quo_fix = dz_q ? 32'hFFFF_FFFF : cond_neg(quo_q, qsign_q);
  assign rem_fix = cond_neg(rem_q[31:0], rsign_q);

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  assign stall_o = rst_n && !flush_i &&
                   ((state_q == S_IDLE && op_valid_i && (is_div_op || is_mul_op)) ||
                    state_q == S_MUL || state_q == S_DIV);
  assign busy_o  = (state_q != S_IDLE);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

  always_comb begin
    result_o       = 32'd0;
    result_valid_o = 1'b0;
    if (rst_n && !flush_i) begin
      if (state_q == S_IDLE && op_valid_i && mdu_op_i == OP_MFHI) begin
        result_o       = hi_q;
        result_valid_o = 1'b1;
      end else if (state_q == S_IDLE && op_valid_i && mdu_op_i == OP_MFLO) begin
        result_o       = lo_q;
        result_valid_o = 1'b1;
      end else if (state_q == S_DONE && op_q == OP_MUL) begin
        result_o       = prod_s[31:0];
        result_valid_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      quo_q   <= 32'd0;
      rem_q   <= 33'd0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      dz_q    <= 1'b0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (op_valid_i) begin
            if (is_div_op) begin
              quo_q   <= cond_neg(rs_data_i, rs_neg);
              b_q     <= cond_neg(rt_data_i, rt_neg);
              qsign_q <= rs_neg ^ rt_neg;
              rsign_q <= rs_neg;
              dz_q    <= (rt_data_i == 32'd0);
              rem_q   <= 33'd0;
              cnt_q   <= 5'd0;
              op_q    <= mdu_op_i;
              state_q <= S_DIV;
            end else if (is_mul_op) begin
              a_q     <= rs_data_i;
              b_q     <= rt_data_i;
              cnt_q   <= 5'd0;
              op_q    <= mdu_op_i;
              state_q <= S_MUL;
            end else if (mdu_op_i == OP_MTHI) begin
              hi_q <= rs_data_i;
            end else if (mdu_op_i == OP_MTLO) begin
              lo_q <= rs_data_i;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == MUL_LAST) begin
            cnt_q   <= 5'd0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DIV: begin
          rem_q <= take ? diff[32:0] : rem_shift[32:0];
          quo_q <= {quo_q[30:0], take};
          if (cnt_q == DIV_LAST) begin
            cnt_q   <= 5'd0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        S_DONE: begin
          if (op_q == OP_DIV || op_q == OP_DIVU) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else if (op_q == OP_MULT) begin
            {hi_q, lo_q} <= prod_s;
          end else if (op_q == OP_MULTU) begin
            {hi_q, lo_q} <= prod_u;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed corner cases plus random ops
// compared against a plain-arithmetic HI/LO model.
module tb_mdu_seq;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mdu_op_i;
  logic        op_valid_i, flush_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic        stall_o, result_valid_o, busy_o;
  logic [31:0] result_o, hi_o, lo_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] hi_m, lo_m;

  mdu_seq #(.MUL_LATENCY(MUL_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mdu_op_i(mdu_op_i), .op_valid_i(op_valid_i),
    .flush_i(flush_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .stall_o(stall_o), .result_o(result_o), .result_valid_o(result_valid_o),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: MIPS semantics straight from integer arithmetic
  task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int est, output logic erv, output logic [31:0] eres);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    est = 0; erv = 1'b0; eres = 32'd0;
    case (op)
      4'd1, 4'd2: begin
        est = 33;
        if (b == 32'd0) begin
          lo_m = 32'hFFFF_FFFF; hi_m = a;
        end else if (op == 4'd1) begin
          q = sa / sb; r = sa % sb;
          lo_m = q[31:0]; hi_m = r[31:0];
        end else begin
          lo_m = 32'(ua / ub); hi_m = 32'(ua % ub);
        end
      end
      4'd3: begin
        est = MUL_LAT + 1; erv = 1'b1;
        q = sa * sb; eres = q[31:0];
      end
      4'd4: begin
        est = MUL_LAT + 1;
        q = sa * sb; {hi_m, lo_m} = q;
      end
      4'd5: begin
        est = MUL_LAT + 1;
        p = ua * ub; {hi_m, lo_m} = p;
      end
      4'd6: begin erv = 1'b1; eres = hi_m; end
      4'd7: begin erv = 1'b1; eres = lo_m; end
      4'd8: hi_m = a;
      4'd9: lo_m = a;
      default: ;
    endcase
  endtask

  // Issue one instruction, hold it until stall drops, return stall count and retire-cycle result
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int stalls, output logic rv, output logic [31:0] res);
    mdu_op_i = op; op_valid_i = 1'b1; rs_data_i = a; rt_data_i = b;
    #1;
    stalls = 0;
    while (stall_o && stalls < 64) begin
      stalls++;
      @(negedge clk); #1;
    end
    rv  = result_valid_o;
    res = result_o;
    @(negedge clk);
    op_valid_i = 1'b0; mdu_op_i = 4'd0;
    #1;
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res);
    int st, est;
    logic rv, erv;
    logic [31:0] eres;
    ref_model(op, a, b, est, erv, eres);
    run_op(op, a, b, st, rv, res);
    check_eq({tag, ".stall"}, 64'(st), 64'(est));
    check_eq({tag, ".rvalid"}, {63'd0, rv}, {63'd0, erv});
    if (erv) check_eq({tag, ".result"}, {32'd0, res}, {32'd0, eres});
    check_eq({tag, ".hi"}, {32'd0, hi_o}, {32'd0, hi_m});
    check_eq({tag, ".lo"}, {32'd0, lo_o}, {32'd0, lo_m});
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 6))
      0: v = 32'd0;
      1: v = 32'h8000_0000;
      2: v = 32'hFFFF_FFFF;
      3: v = 32'd1;
      4: v = $urandom_range(0, 20);
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    logic [31:0] r;
    logic [3:0]  op;
    rst_n = 1'b0; mdu_op_i = 4'd0; op_valid_i = 1'b0; flush_i = 1'b0;
    rs_data_i = 32'd0; rt_data_i = 32'd0;
    hi_m = 32'd0; lo_m = 32'd0;
    #1;
    check_eq("rst.busy", {63'd0, busy_o}, 64'd0);
    check_eq("rst.stall", {63'd0, stall_o}, 64'd0);
    check_eq("rst.rvalid", {63'd0, result_valid_o}, 64'd0);
    check_eq("rst.hi", {32'd0, hi_o}, 64'd0);
    check_eq("rst.lo", {32'd0, lo_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;

    do_op("divu100_7", 4'd2, 32'd100, 32'd7, r);
    check_eq("divu100_7.lo_lit", {32'd0, lo_o}, 64'd14);
    check_eq("divu100_7.hi_lit", {32'd0, hi_o}, 64'd2);
    do_op("mflo_next", 4'd7, 32'd0, 32'd0, r);
    check_eq("mflo_next.lit", {32'd0, r}, 64'd14);

    do_op("div_m7_2", 4'd1, 32'hFFFF_FFF9, 32'd2, r);
    check_eq("div_m7_2.lo_lit", {32'd0, lo_o}, 64'hFFFF_FFFD);
    check_eq("div_m7_2.hi_lit", {32'd0, hi_o}, 64'hFFFF_FFFF);
    do_op("div_ovf", 4'd1, 32'h8000_0000, 32'hFFFF_FFFF, r);
    check_eq("div_ovf.lo_lit", {32'd0, lo_o}, 64'h8000_0000);
    check_eq("div_ovf.hi_lit", {32'd0, hi_o}, 64'd0);

    do_op("mult", 4'd4, 32'hFFFF_FFFF, 32'd2, r);
    check_eq("mult.hilo_lit", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op("multu", 4'd5, 32'hFFFF_FFFF, 32'd2, r);
    check_eq("multu.hilo_lit", {hi_o, lo_o}, 64'h0000_0001_FFFF_FFFE);

    do_op("mthi", 4'd8, 32'h55, 32'd0, r);
    do_op("mul", 4'd3, 32'h1_0000, 32'h1_0000, r);
    check_eq("mul.res_lit", {32'd0, r}, 64'd0);
    check_eq("mul.hi_lit", {32'd0, hi_o}, 64'h55);

    do_op("divu_dz", 4'd2, 32'd9, 32'd0, r);
    check_eq("divu_dz.lo_lit", {32'd0, lo_o}, 64'hFFFF_FFFF);
    check_eq("divu_dz.hi_lit", {32'd0, hi_o}, 64'd9);
    do_op("div_dz_neg", 4'd1, 32'hFFFF_FFF0, 32'd0, r);

    // Flush a divide at T10
    mdu_op_i = 4'd1; op_valid_i = 1'b1; rs_data_i = 32'd1000; rt_data_i = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    flush_i = 1'b1;
    #1;
    check_eq("flush.stall_t10", {63'd0, stall_o}, 64'd0);
    check_eq("flush.busy_t10", {63'd0, busy_o}, 64'd1);
    @(negedge clk);
    flush_i = 1'b0; op_valid_i = 1'b0; mdu_op_i = 4'd0;
    #1;
    check_eq("flush.busy_t11", {63'd0, busy_o}, 64'd0);
    check_eq("flush.hi", {32'd0, hi_o}, {32'd0, hi_m});
    check_eq("flush.lo", {32'd0, lo_o}, {32'd0, lo_m});

    // A flushed MTHI must not write
    flush_i = 1'b1; mdu_op_i = 4'd8; op_valid_i = 1'b1; rs_data_i = 32'hDEAD_BEEF;
    @(negedge clk);
    flush_i = 1'b0; op_valid_i = 1'b0; mdu_op_i = 4'd0;
    #1;
    check_eq("flush_mthi.hi", {32'd0, hi_o}, {32'd0, hi_m});

    // Random traffic against the model
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 9));
      do_op($sformatf("rnd%0d_op%0d", i, op), op, pick_operand(), pick_operand(), r);
    end

    // Reset mid-divide at T5
    do_op("pre_rst", 4'd9, 32'h1234_5678, 32'd0, r);
    mdu_op_i = 4'd1; op_valid_i = 1'b1; rs_data_i = 32'd77; rt_data_i = 32'd5;
    repeat (5) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst.busy", {63'd0, busy_o}, 64'd0);
    check_eq("midrst.stall", {63'd0, stall_o}, 64'd0);
    check_eq("midrst.hi", {32'd0, hi_o}, 64'd0);
    check_eq("midrst.lo", {32'd0, lo_o}, 64'd0);
    hi_m = 32'd0; lo_m = 32'd0;
    @(negedge clk);
    op_valid_i = 1'b0; mdu_op_i = 4'd0;
    rst_n = 1'b1;
    #1;
    do_op("post_rst_multu", 4'd5, 32'd3, 32'd4, r);
    check_eq("post_rst.hilo_lit", {hi_o, lo_o}, 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
